dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data memory (dmem) of the 16-bit computer between the MIPS CPU (port 0) and a loader/debug master (port 1).
- Uses a round-robin grant with a combinational grant path, so an uncontended CPU access completes in the same cycle.
- A lock handshake gives atomic multi-cycle ownership, bounded by a timeout.
- Per-port saturating grant counters support bench and performance checking.

Parameters:
- N, 16, data width (matches the GPR/dmem word).
- A, 16, address width (matches dataadr).
- MAX_LOCK, 8, maximum consecutive cycles a locked owner may hold the memory.
- CW, 16, width of the grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  2  per-port access request; bit i belongs to port i.
- lock  in  2  per-port lock request; meaningful only while that port is granted.
- we  in  2  per-port write enable.
- addr0, addr1  in  A  per-port address.
- wd0, wd1  in  N  per-port write data.
- gnt  out  2  one-hot or zero; a transfer occurs on the rising edge where req[i]&gnt[i]=1.
- rdata  out  N  memory read data, broadcast to both ports; valid when gnt[i]=1.
- mem_addr  out  A  address to dmem.
- mem_wd  out  N  write data to dmem.
- mem_we  out  1  write strobe to dmem.
- mem_rd  in  N  combinational read data from dmem.
- lock_err  out  1  sticky flag: a lock timeout occurred.
- gcnt0, gcnt1  out  CW  saturating count of completed transfers per port.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=1 (port 0 preferred first), lock_cnt=0, lock_err=0, gcnt0=gcnt1=0.
- While reset=0: gnt=0 and mem_we=0, forced combinationally. mem_addr and mem_wd are don't-care.
- FSM states:
  - IDLE: no lock held.
  - LOCK0: port 0 owns the memory.
  - LOCK1: port 1 owns the memory.
- Grant in IDLE:
  - Exactly one req high -> grant that port.
  - Both req high -> grant port (rr+1) mod 2.
  - No req -> gnt=0.
- Grant in LOCKi: gnt[i]=req[i]; the other port's gnt is 0 regardless of its req.
- Memory mux:
  - mem_addr, mem_wd and the we select come from the granted port; when nothing is granted they come from port 0.
  - mem_we = |(gnt & req & we).
  - rdata = mem_rd, always.
- Transfer bookkeeping:
  - On the edge with a transfer on port i: rr <= i.
  - gcnt_i increments and saturates at 2^CW-1 (no wrap).
- Lock transitions:
  - IDLE -> LOCKi: on a transfer edge where lock[i]=1; lock_cnt <= 1.
  - LOCKi -> IDLE: when lock[i]=0 at a rising edge (the release can coincide with a final transfer).
  - LOCKi -> IDLE (timeout): when lock_cnt reaches MAX_LOCK at a rising edge with lock[i] still 1. lock_err <= 1 and rr <= i, so the other port wins next.
  - While in LOCKi, lock_cnt increments every cycle, whether or not a transfer occurs.
- After a timeout, the same port may not re-lock in the very next cycle if the other port is requesting: normal round-robin applies.
- Protocol: a requester holds req, we, addr and wd stable until it sees gnt. Keeping req high after a transfer is a new request.
- If req drops with no gnt, nothing happens: there is no pending state.
- lock without a grant is ignored.
- lock_err is cleared only by reset.
- Reset mid-lock: returns to IDLE immediately; no memory write is issued during reset.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum state_t {IDLE, LOCK0, LOCK1};
  - constants NPORTS=2, CPU_PORT=0, LDR_PORT=1.
- One natural sub-module: sat_counter (parameter CW; inputs clk, reset, inc; output count), instantiated twice for gcnt0/gcnt1.

Test Plan:
- Reset: hold reset=0 with req=2'b11 and we=2'b11 -> gnt=00, mem_we=0, gcnt0=gcnt1=0, lock_err=0. Release -> port 0 granted first.
- Contention: req=11 for 4 cycles, addr0=0x0054, wd0=0x0096, addr1=0x0010, wd1=0x1234, we=11:
  - gnt sequence 01, 10, 01, 10;
  - dmem RAM[84]=0x0096 and RAM[16]=0x1234;
  - gcnt0=gcnt1=2.
- Single port: only req[0] high with we=0 -> gnt=01 in the same cycle, rdata equals dmem word at addr0, no stall; repeat 3 cycles -> gcnt0=3.
- Lock: port 1 sets lock=1 and req=1 for 3 cycles while req[0]=1 -> gnt=10 all 3 cycles; port 1 drops lock -> the next cycle grants port 0.
- Timeout: MAX_LOCK=8, port 1 holds lock=1 indefinitely while req[0]=1 -> after 8 locked cycles lock_err=1, the FSM returns to IDLE, and the following grant goes to port 0.
- Saturation: CW=4, 20 port-0 transfers -> gcnt0=15 and holds at 15.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the dmem arbiter
//
// Purpose: FSM state encoding, port indices and the round-robin pick
//          function used by dmem_arbiter.
// Contents:
//   state_t   IDLE / LOCK0 / LOCK1 arbiter ownership state
//   NPORTS    number of requesting ports (2)
//   CPU_PORT  port index of the MIPS CPU (0)
//   LDR_PORT  port index of the loader/debug master (1)
//   rr_pick   one-hot grant for the unlocked case

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam int NPORTS   = 2;
  localparam int CPU_PORT = 0;
  localparam int LDR_PORT = 1;

  // rr holds the port that won last; on contention the other port goes.
  function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                                 input logic              rr);
    logic [NPORTS-1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = rr ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose: counts inc pulses and sticks at the all-ones value.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset, clears count
//   inc    in   count enable for this cycle
//   count  out  current count, saturates at 2^CW-1

module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with lock for the data memory
//
// Purpose: shares one combinational-read dmem between the CPU (port 0) and the
//          loader/debug master (port 1). Grants are combinational so an
//          uncontended access completes in the same cycle. A granted port can
//          lock the memory for atomic sequences; a lock held for MAX_LOCK
//          cycles is broken and flagged in lock_err.
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   req[1:0]      in   per-port access request
//   lock[1:0]     in   per-port lock request, only honoured while granted
//   we[1:0]       in   per-port write enable
//   addr0/addr1   in   per-port address
//   wd0/wd1       in   per-port write data
//   gnt[1:0]      out  one-hot or zero grant; transfer when req&gnt
//   rdata         out  dmem read data, shared by both ports
//   mem_addr      out  address to dmem
//   mem_wd        out  write data to dmem
//   mem_we        out  write strobe to dmem
//   mem_rd        in   combinational read data from dmem
//   lock_err      out  sticky lock-timeout flag
//   gcnt0/gcnt1   out  saturating completed-transfer counts per port

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int A        = 16,
  parameter int MAX_LOCK = 8,
  parameter int CW       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] lock,
  input  logic [NPORTS-1:0] we,
  input  logic [A-1:0]      addr0,
  input  logic [A-1:0]      addr1,
  input  logic [N-1:0]      wd0,
  input  logic [N-1:0]      wd1,
  output logic [NPORTS-1:0] gnt,
  output logic [N-1:0]      rdata,
  output logic [A-1:0]      mem_addr,
  output logic [N-1:0]      mem_wd,
  output logic              mem_we,
  input  logic [N-1:0]      mem_rd,
  output logic              lock_err,
  output logic [CW-1:0]     gcnt0,
  output logic [CW-1:0]     gcnt1
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_LIMIT = LW'(MAX_LOCK);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

  state_t            state;
  logic              rr;
  logic [LW-1:0]     lock_cnt;
  logic [NPORTS-1:0] xfer;

  // Grant is a pure function of state, rr and req so that a lone CPU access
  // is serviced in the cycle it is raised. Reset forces it off.
  always_comb begin
    gnt = '0;
    if (reset) begin
      unique case (state)
        IDLE:    gnt = rr_pick(req, rr);
        LOCK0:   gnt[CPU_PORT] = req[CPU_PORT];
        LOCK1:   gnt[LDR_PORT] = req[LDR_PORT];
        default: gnt = '0;
      endcase
    end
  end

  assign xfer = gnt & req;

  // Port 0 drives the memory bus whenever port 1 is not granted.
  always_comb begin
    mem_addr = addr0;
    mem_wd   = wd0;
    if (gnt[LDR_PORT]) begin
      mem_addr = addr1;
      mem_wd   = wd1;
    end
  end

  assign mem_we = |(xfer & we);
  assign rdata  = mem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr       <= 1'b1;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      if (xfer[CPU_PORT]) begin
        rr <= 1'b0;
      end else if (xfer[LDR_PORT]) begin
        rr <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (xfer[CPU_PORT] && lock[CPU_PORT]) begin
            state    <= LOCK0;
            lock_cnt <= LOCK_ONE;
          end else if (xfer[LDR_PORT] && lock[LDR_PORT]) begin
            state    <= LOCK1;
            lock_cnt <= LOCK_ONE;
          end
        end

        LOCK0: begin
          if (!lock[CPU_PORT]) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LIMIT) begin
            // Break the lock and hand priority to the other port.
            state    <= IDLE;
            lock_cnt <= '0;
            lock_err <= 1'b1;
            rr       <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LOCK_ONE;
          end
        end

        LOCK1: begin
          if (!lock[LDR_PORT]) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LIMIT) begin
            state    <= IDLE;
            lock_cnt <= '0;
            lock_err <= 1'b1;
            rr       <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LOCK_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_gcnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (xfer[CPU_PORT]),
    .count (gcnt0)
  );

  sat_counter #(.CW(CW)) u_gcnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (xfer[LDR_PORT]),
    .count (gcnt1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

  localparam int N  = 16;
  localparam int A  = 16;
  localparam int ML = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, lock, we;
  logic [A-1:0]  addr0, addr1;
  logic [N-1:0]  wd0, wd1;
  logic [1:0]    gnt;
  logic [N-1:0]  rdata;
  logic [A-1:0]  mem_addr;
  logic [N-1:0]  mem_wd;
  logic          mem_we;
  logic [N-1:0]  mem_rd;
  logic          lock_err;
  logic [CW-1:0] gcnt0, gcnt1;

  logic [N-1:0] ram [0:255];

  typedef struct packed {
    logic [A-1:0] a;
    logic [N-1:0] d;
  } wr_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  logic [1:0] exp_gnt_q[$];
  logic [N-1:0] exp_rd_q[$];
  wr_t       exp_wr_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wd;
  end
  assign mem_rd = ram[mem_addr[7:0]];

  dmem_arbiter #(.N(N), .A(A), .MAX_LOCK(ML), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .addr0    (addr0),
    .addr1    (addr1),
    .wd0      (wd0),
    .wd1      (wd1),
    .gnt      (gnt),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .lock_err (lock_err),
    .gcnt0    (gcnt0),
    .gcnt1    (gcnt1)
  );

  // Drive one cycle's inputs at the falling edge and let combinational paths settle.
  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    we   = w;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 2'b11; we = 2'b11; lock = 2'b00;
    addr0 = 16'h0021; addr1 = 16'h0022; wd0 = 16'hDEAD; wd1 = 16'hDEAD;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_tests++; if (gcnt0 !== 4'd0 || gcnt1 !== 4'd0) begin n_fail++; $display("FAIL reset_gcnt: got %0d/%0d expected 0/0", gcnt0, gcnt1); end
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL reset_lock_err: got %b expected 0", lock_err); end
    @(negedge clk);
    reset = 1'b1;
    we = 2'b00;
    #1;
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 01", gnt); end
    // Request withdrawn before any edge: no transfer, no pending state.
    req = 2'b00;
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_req_drop: got %b expected 00", gnt); end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd0) begin n_fail++; $display("FAIL reset_no_pending: got %0d expected 0", gcnt0); end
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    wr_t        w;
    addr0 = 16'h0054; wd0 = 16'h0096;
    addr1 = 16'h0010; wd1 = 16'h1234;
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    exp_wr_q.push_back('{a: 16'h0054, d: 16'h0096});
    exp_wr_q.push_back('{a: 16'h0010, d: 16'h1234});
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, 2'b11);
      eg = exp_gnt_q.pop_front();
      n_tests++; if (gnt !== eg) begin n_fail++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, gnt, eg); end
      n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL contention_we[%0d]: got %b expected 1", i, mem_we); end
      n_tests++; if (mem_addr !== (eg[1] ? addr1 : addr0)) begin n_fail++; $display("FAIL contention_addr[%0d]: got %h expected %h", i, mem_addr, eg[1] ? addr1 : addr0); end
    end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd2 || gcnt1 !== 4'd2) begin n_fail++; $display("FAIL contention_gcnt: got %0d/%0d expected 2/2", gcnt0, gcnt1); end
    while (exp_wr_q.size() > 0) begin
      w = exp_wr_q.pop_front();
      n_tests++; if (ram[w.a[7:0]] !== w.d) begin n_fail++; $display("FAIL contention_ram[%h]: got %h expected %h", w.a, ram[w.a[7:0]], w.d); end
    end
  endtask

  task automatic test_single_port();
    logic [A-1:0] addrs [3];
    logic [N-1:0] er;
    addrs[0] = 16'h0054; addrs[1] = 16'h0010; addrs[2] = 16'h0054;
    exp_rd_q.push_back(16'h0096); exp_rd_q.push_back(16'h1234); exp_rd_q.push_back(16'h0096);
    for (int i = 0; i < 3; i++) begin
      addr0 = addrs[i];
      step(2'b01, 2'b00, 2'b00);
      er = exp_rd_q.pop_front();
      n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b expected 01", i, gnt); end
      n_tests++; if (rdata !== er) begin n_fail++; $display("FAIL single_rdata[%0d]: got %h expected %h", i, rdata, er); end
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we[%0d]: got %b expected 0", i, mem_we); end
    end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd5) begin n_fail++; $display("FAIL single_gcnt0: got %0d expected 5", gcnt0); end
  endtask

  task automatic test_lock();
    logic [1:0] rq [5];
    logic [1:0] lk [5];
    logic [1:0] eg;
    // A lock bit without a grant is ignored, then port 1 locks for three
    // transfers, releasing on the last one; port 0 follows immediately.
    rq[0] = 2'b01; lk[0] = 2'b10; exp_gnt_q.push_back(2'b01);
    rq[1] = 2'b11; lk[1] = 2'b10; exp_gnt_q.push_back(2'b10);
    rq[2] = 2'b11; lk[2] = 2'b10; exp_gnt_q.push_back(2'b10);
    rq[3] = 2'b11; lk[3] = 2'b00; exp_gnt_q.push_back(2'b10);
    rq[4] = 2'b11; lk[4] = 2'b00; exp_gnt_q.push_back(2'b01);
    for (int i = 0; i < 5; i++) begin
      step(rq[i], lk[i], 2'b00);
      eg = exp_gnt_q.pop_front();
      n_tests++; if (gnt !== eg) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt, eg); end
    end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd7 || gcnt1 !== 4'd5) begin n_fail++; $display("FAIL lock_gcnt: got %0d/%0d expected 7/5", gcnt0, gcnt1); end
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lock_err_clean: got %b expected 0", lock_err); end
  endtask

  task automatic test_timeout();
    logic [1:0] eg;
    logic       ee;
    // Entry grant plus ML locked cycles, then the lock is broken.
    for (int i = 0; i < ML + 1; i++) exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01);
    for (int i = 0; i < ML + 2; i++) begin
      step(2'b11, 2'b10, 2'b00);
      eg = exp_gnt_q.pop_front();
      ee = (i == ML + 1);
      n_tests++; if (gnt !== eg) begin n_fail++; $display("FAIL timeout_gnt[%0d]: got %b expected %b", i, gnt, eg); end
      n_tests++; if (lock_err !== ee) begin n_fail++; $display("FAIL timeout_err[%0d]: got %b expected %b", i, lock_err, ee); end
    end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd8 || gcnt1 !== 4'd14) begin n_fail++; $display("FAIL timeout_gcnt: got %0d/%0d expected 8/14", gcnt0, gcnt1); end
    n_tests++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", lock_err); end
  endtask

  task automatic test_saturation();
    int ec;
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 2'b00, 2'b00);
      ec = (8 + i > 15) ? 15 : 8 + i;
      n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sat_gnt[%0d]: got %b expected 01", i, gnt); end
      n_tests++; if (gcnt0 !== ec[CW-1:0]) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, gcnt0, ec); end
    end
    step(2'b00, 2'b00, 2'b00);
    n_tests++; if (gcnt0 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", gcnt0); end
    n_tests++; if (gcnt1 !== 4'd14 || lock_err !== 1'b1) begin n_fail++; $display("FAIL sat_others: got %0d/%b expected 14/1", gcnt1, lock_err); end
  endtask

  task automatic test_reset_midlock();
    wr_t w;
    addr0 = 16'h0020; wd0 = 16'hBEEF;
    exp_wr_q.push_back('{a: 16'h0020, d: 16'hBEEF});
    step(2'b01, 2'b01, 2'b01);
    n_tests++; if (gnt !== 2'b01 || mem_we !== 1'b1) begin n_fail++; $display("FAIL midlock_enter: got %b/%b expected 01/1", gnt, mem_we); end
    step(2'b01, 2'b01, 2'b01);
    reset = 1'b0;
    #1;
    n_tests++; if (gnt !== 2'b00 || mem_we !== 1'b0) begin n_fail++; $display("FAIL midlock_reset_out: got %b/%b expected 00/0", gnt, mem_we); end
    n_tests++; if (lock_err !== 1'b0 || gcnt0 !== 4'd0 || gcnt1 !== 4'd0) begin n_fail++; $display("FAIL midlock_reset_regs: got %b/%0d/%0d expected 0/0/0", lock_err, gcnt0, gcnt1); end
    @(negedge clk);
    reset = 1'b1;
    req = 2'b10; lock = 2'b00; we = 2'b00;
    #1;
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL midlock_idle: got %b expected 10", gnt); end
    w = exp_wr_q.pop_front();
    n_tests++; if (ram[w.a[7:0]] !== w.d) begin n_fail++; $display("FAIL midlock_ram: got %h expected %h", ram[w.a[7:0]], w.d); end
    step(2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single_port();
    test_lock();
    test_timeout();
    test_saturation();
    test_reset_midlock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
